decode: RTL and testbench

Instruction-decode stage of the five-stage pipeline, directly downstream of the fetch stage. It consumes the IF/ID instruction and next-PC and decodes the opcode into WB/M/EX control groups. It reads two operands from a 32×32 register file, which the MEM/WB write-back port updates, and sign-extends the immediate. All results are registered into the ID/EX latch that feeds the execute stage.

---
 rtl/decode_if.sv | 38 +++
 rtl/decode.sv | 97 +++++++++
 tb/tb_decode.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// decode_if: groups the decode stage's pipeline-latch signals.
//   if_id_instr / if_id_npc          : instruction and PC+4 from the IF/ID latch
//   mem_wb_reg_write / _write_reg /
//   mem_wb_write_data                : register-file write-back port from MEM/WB
//   id_ex_wb / id_ex_m / id_ex_ex    : registered control groups toward EX
//   id_ex_npc, id_ex_rdata1/2,
//   id_ex_imm, id_ex_rt, id_ex_rd    : registered datapath fields toward EX
// The master drives the stage inputs; the slave (decode) drives the ID/EX latch.
interface decode_if;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg;
    logic [31:0] mem_wb_write_data;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rdata1;
    logic [31:0] id_ex_rdata2;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;

    modport master (
        output if_id_instr, if_id_npc,
        output mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
        input  id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc,
        input  id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_rt, id_ex_rd
    );

    modport slave (
        input  if_id_instr, if_id_npc,
        input  mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
        output id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc,
        output id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_rt, id_ex_rd
    );
endinterface

// File: rtl/decode.sv
// decode: instruction-decode pipeline stage.
//   clk  : pipeline clock, all state updates on rising edge
//   rst  : synchronous active-high reset (clears ID/EX latch and register file)
//   bus  : decode_if.slave -- IF/ID inputs, MEM/WB write-back port, ID/EX outputs
// Decodes the opcode into WB/M/EX control groups, reads two operands from a
// 32x32 register file (with write-through bypass from write-back), sign-extends
// the immediate and registers everything into the ID/EX latch.
module decode (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_BEQ   = 6'd4,
        OP_LW    = 6'd35,
        OP_SW    = 6'd43
    } opcode_e;

    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        wr_en;
    logic [1:0]  wb_c;
    logic [2:0]  m_c;
    logic [3:0]  ex_c;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;

    always_comb begin
        opcode = bus.if_id_instr[31:26];
        rs     = bus.if_id_instr[25:21];
        rt     = bus.if_id_instr[20:16];
        rd     = bus.if_id_instr[15:11];
        imm    = {{16{bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
        // Writes to r0 are discarded, so the enable already excludes index 0.
        wr_en  = bus.mem_wb_reg_write && (bus.mem_wb_write_reg != '0);
    end

    // Control groups: wb={reg_write,mem_to_reg}, m={branch,mem_read,mem_write},
    // ex={reg_dst,alu_op[1:0],alu_src}. Unknown opcodes become a bubble.
    always_comb begin
        wb_c = '0;
        m_c  = '0;
        ex_c = '0;
        case (opcode)
            OP_RTYPE: begin ex_c = 4'b1100; m_c = 3'b000; wb_c = 2'b10; end
            OP_LW:    begin ex_c = 4'b0001; m_c = 3'b010; wb_c = 2'b11; end
            OP_SW:    begin ex_c = 4'b0001; m_c = 3'b001; wb_c = 2'b00; end
            OP_BEQ:   begin ex_c = 4'b0010; m_c = 3'b100; wb_c = 2'b00; end
            default:  begin ex_c = '0;      m_c = '0;     wb_c = '0;     end
        endcase
    end

    // Read ports: r0 hardwired to zero; a same-cycle write-back to the read
    // index is forwarded so the ID/EX latch sees the new value at this edge.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs != '0)
            rdata1 = (wr_en && bus.mem_wb_write_reg == rs) ? bus.mem_wb_write_data : regs[rs];
        if (rt != '0)
            rdata2 = (wr_en && bus.mem_wb_write_reg == rt) ? bus.mem_wb_write_data : regs[rt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[5'(i)] <= '0;
            bus.id_ex_wb     <= '0;
            bus.id_ex_m      <= '0;
            bus.id_ex_ex     <= '0;
            bus.id_ex_npc    <= '0;
            bus.id_ex_rdata1 <= '0;
            bus.id_ex_rdata2 <= '0;
            bus.id_ex_imm    <= '0;
            bus.id_ex_rt     <= '0;
            bus.id_ex_rd     <= '0;
        end else begin
            if (wr_en)
                regs[bus.mem_wb_write_reg] <= bus.mem_wb_write_data;
            bus.id_ex_wb     <= wb_c;
            bus.id_ex_m      <= m_c;
            bus.id_ex_ex     <= ex_c;
            bus.id_ex_npc    <= bus.if_id_npc;
            bus.id_ex_rdata1 <= rdata1;
            bus.id_ex_rdata2 <= rdata2;
            bus.id_ex_imm    <= imm;
            bus.id_ex_rt     <= rt;
            bus.id_ex_rd     <= rd;
        end
    end
endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for the decode stage. Stimulus is driven on the
// falling edge and the expected ID/EX contents are pushed into a queue; a
// monitor pops and compares one entry after every rising edge.
module tb_decode;
    logic clk = 1'b0;
    logic rst;

    decode_if bus ();

    decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model_regs [32];
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int          popped = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (txn %0d)", name, act, expv, popped);
        end
    endtask

    // Reference model: apply the write-back first, then read -- this is the
    // "write-back visible in the same cycle" rule stated directly.
    task automatic issue(input logic r, input logic [31:0] instr, input logic [31:0] npc,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        exp_t e;
        logic [5:0] op;
        @(negedge clk);
        rst                   = r;
        bus.if_id_instr       = instr;
        bus.if_id_npc         = npc;
        bus.mem_wb_reg_write  = we;
        bus.mem_wb_write_reg  = wr;
        bus.mem_wb_write_data = wd;
        e = '{default: '0};
        if (r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        end else begin
            if (we && wr != 5'd0) model_regs[wr] = wd;
            op = instr[31:26];
            case (op)
                6'd0:    begin e.ex = 4'b1100; e.m = 3'b000; e.wb = 2'b10; end
                6'd35:   begin e.ex = 4'b0001; e.m = 3'b010; e.wb = 2'b11; end
                6'd43:   begin e.ex = 4'b0001; e.m = 3'b001; e.wb = 2'b00; end
                6'd4:    begin e.ex = 4'b0010; e.m = 3'b100; e.wb = 2'b00; end
                default: begin e.ex = 4'b0000; e.m = 3'b000; e.wb = 2'b00; end
            endcase
            e.npc = npc;
            e.rd1 = (instr[25:21] == 5'd0) ? 32'h0 : model_regs[instr[25:21]];
            e.rd2 = (instr[20:16] == 5'd0) ? 32'h0 : model_regs[instr[20:16]];
            e.imm = 32'(signed'(instr[15:0]));
            e.rt  = instr[20:16];
            e.rd  = instr[15:11];
        end
        exp_q.push_back(e);
        issued++;
    endtask

    function automatic logic [31:0] mk(input int op, input int rs, input int rt, input logic [15:0] lo);
        return {6'(op), 5'(rs), 5'(rt), lo};
    endfunction

    // Monitor: the latch updates every edge, so one entry is due per edge
    // once stimulus has been issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                check("wb",     32'(bus.id_ex_wb),  32'(e.wb));
                check("m",      32'(bus.id_ex_m),   32'(e.m));
                check("ex",     32'(bus.id_ex_ex),  32'(e.ex));
                check("npc",    bus.id_ex_npc,      e.npc);
                check("rdata1", bus.id_ex_rdata1,   e.rd1);
                check("rdata2", bus.id_ex_rdata2,   e.rd2);
                check("imm",    bus.id_ex_imm,      e.imm);
                check("rt",     32'(bus.id_ex_rt),  32'(e.rt));
                check("rd",     32'(bus.id_ex_rd),  32'(e.rd));
            end
        end
    end

    initial begin
        logic [31:0] instr;
        logic [4:0]  wr;
        int          sel;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        rst = 1'b1;
        bus.if_id_instr = '0; bus.if_id_npc = '0;
        bus.mem_wb_reg_write = 1'b0; bus.mem_wb_write_reg = '0; bus.mem_wb_write_data = '0;

        // Reset with busy inputs and an active write-back that must be ignored.
        issue(1'b1, 32'h00A63820, 32'h44, 1'b1, 5'd5, 32'hCAFEF00D);
        issue(1'b1, 32'h8CA5FFFC, 32'h48, 1'b1, 5'd6, 32'h0BADBEEF);
        // Post-reset reads of r5/r6 must be zero.
        issue(1'b0, mk(0, 5, 6, 16'h3820), 32'h4, 1'b0, 5'd0, 32'h0);
        // Write r5, then add r7,r5,r6.
        issue(1'b0, 32'h0, 32'h4, 1'b1, 5'd5, 32'hDEADBEEF);
        issue(1'b0, 32'h00A63820, 32'h8, 1'b0, 5'd0, 32'h0);
        // Bypass: write r6 while decoding an instruction with rt=r6.
        issue(1'b0, 32'h00A63820, 32'hC, 1'b1, 5'd6, 32'h12345678);
        // r0 protection: same-cycle and later read.
        issue(1'b0, mk(0, 0, 0, 16'h0000), 32'h10, 1'b1, 5'd0, 32'hFFFFFFFF);
        issue(1'b0, mk(0, 0, 0, 16'h0000), 32'h14, 1'b0, 5'd0, 32'h0);
        // lw / sw / beq / unknown opcode.
        issue(1'b0, mk(35, 5, 8, 16'hFFFC), 32'h18, 1'b0, 5'd0, 32'h0);
        issue(1'b0, mk(43, 5, 6, 16'h0010), 32'h1C, 1'b0, 5'd0, 32'h0);
        issue(1'b0, mk(4,  5, 6, 16'h8001), 32'h20, 1'b0, 5'd0, 32'h0);
        issue(1'b0, mk(63, 5, 6, 16'h9ABC), 32'h24, 1'b0, 5'd0, 32'h0);

        // Randomized traffic with occasional mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 4));
            instr = $urandom;
            case (sel)
                0: instr[31:26] = 6'd0;
                1: instr[31:26] = 6'd35;
                2: instr[31:26] = 6'd43;
                3: instr[31:26] = 6'd4;
                default: ;
            endcase
            wr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) instr[25:21] = wr;
            if ($urandom_range(0, 3) == 0) instr[20:16] = wr;
            issue(($urandom_range(0, 99) == 0), instr, $urandom,
                  ($urandom_range(0, 1) == 1), wr, $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || popped != issued) begin
            errors++;
            $display("FAIL drain: popped %0d expected %0d", popped, issued);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
